// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: register file geometry, write-back selects, bubble encoding.
package mips_pkg;

    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 32;
    localparam int unsigned IW   = 32;

    localparam logic [DW-1:0] LINK_OFS = 32'd8;

    typedef enum logic [1:0] {
        WSEL_ALU  = 2'b00,
        WSEL_DM   = 2'b01,
        WSEL_LINK = 2'b10,
        WSEL_NONE = 2'b11
    } wsel_e;

    localparam logic [AW-1:0] REG_ZERO = 5'd0;
    localparam logic [IW-1:0] NOP      = 32'h0;

endpackage

// File: rtl/grf_array.sv
// NREG x DW register storage: async active-low clear, one write port, two raw read ports (no bypass).
module grf_array
    import mips_pkg::*;
(
    input  logic          clk,
    input  logic          clr,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr_a,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] rdata_a,
    output logic [DW-1:0] rdata_b
);

    logic [DW-1:0] regs [NREG];

    // Entry 0 is never written, so it stays at its cleared value of zero.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != REG_ZERO)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/grf_wb_stage.sv
// WB stage: write-back mux, GRF with same-cycle WB->ID bypass, forwarding source, retire counter.
// Optional WB_TRACE_EN adds a simulation-only write trace.
module grf_wb_stage
    import mips_pkg::*;
(
    input  logic          clk,
    input  logic          clr,
    input  logic [IW-1:0] ins_WB,
    input  logic [DW-1:0] pc_WB,
    input  logic [DW-1:0] alu_WB,
    input  logic [DW-1:0] dm_WB,
    input  logic [AW-1:0] rd_WB,
    input  logic [1:0]    wsel_WB,
    input  logic [1:0]    Tnew_WB,
    input  logic [AW-1:0] rs_addr,
    input  logic [AW-1:0] rt_addr,
    output logic [DW-1:0] rs_data,
    output logic [DW-1:0] rt_data,
    output logic          fwd_valid,
    output logic [AW-1:0] fwd_rd,
    output logic [DW-1:0] fwd_data,
    output logic [31:0]   retire_cnt
);

    logic [DW-1:0] wd;
    logic          wen;
    logic [DW-1:0] raw_a;
    logic [DW-1:0] raw_b;

    always_comb begin
        wd = '0;
        case (wsel_WB)
            WSEL_ALU:  wd = alu_WB;
            WSEL_DM:   wd = dm_WB;
            WSEL_LINK: wd = pc_WB + LINK_OFS;
            default:   wd = '0;
        endcase
    end

    assign wen = clr && (wsel_WB != WSEL_NONE) && (rd_WB != REG_ZERO) && (ins_WB != NOP);

    grf_array u_grf (
        .clk     (clk),
        .clr     (clr),
        .we      (wen),
        .waddr   (rd_WB),
        .wdata   (wd),
        .raddr_a (rs_addr),
        .raddr_b (rt_addr),
        .rdata_a (raw_a),
        .rdata_b (raw_b)
    );

    // Bypass lets ID see the value being written in this very cycle.
    always_comb begin
        rs_data = raw_a;
        rt_data = raw_b;
        if (rs_addr == REG_ZERO) begin
            rs_data = '0;
        end else if (wen && (rs_addr == rd_WB)) begin
            rs_data = wd;
        end
        if (rt_addr == REG_ZERO) begin
            rt_data = '0;
        end else if (wen && (rt_addr == rd_WB)) begin
            rt_data = wd;
        end
    end

    // A nonzero Tnew in WB still writes but is never offered for forwarding.
    assign fwd_valid = wen && (Tnew_WB == 2'd0);
    assign fwd_rd    = fwd_valid ? rd_WB : '0;
    assign fwd_data  = fwd_valid ? wd : '0;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            retire_cnt <= '0;
        end else if (ins_WB != NOP) begin
            retire_cnt <= retire_cnt + 32'd1;
        end
    end

`ifdef WB_TRACE_EN
    always_ff @(posedge clk) begin
        if (wen) begin
            $display("@%h: $%d <= %h", pc_WB, rd_WB, wd);
        end
    end
`endif

endmodule
